sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, parametrised FIFO that generalises the team's asynchronous FIFO for same-domain buffering. Width and depth are configurable, and read mode is selectable between registered-output and first-word-fall-through (FWFT). It adds programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and replaces ad-hoc register stages in datapaths.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2; AW = log2(DEPTH)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented on dout without r_en
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- w_en  input  1  write request
- din  input  WIDTH  write data
- r_en  input  1  read request (pop)
- err_clr  input  1  clears overflow/underflow sticky flags
- dout  output  WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write rejected since last clear
- underflow  output  1  sticky: read rejected since last clear

## Operation
- Storage: DEPTH×WIDTH array. Read and write pointers are AW bits wide and wrap modulo DEPTH. count is a registered AW+1-bit counter.
- Write accept: wa = w_en & (!full | ra). A write into a full FIFO succeeds only when a read is accepted in the same cycle.
- Read accept: ra = r_en & !empty. A read of an empty FIFO is always rejected, even with a simultaneous write.
- Count update: count += wa − ra, so a simultaneous accepted read and write leaves count unchanged.
- overflow set when w_en & !wa; underflow set when r_en & empty.
- Sticky flags clear on err_clr or reset. Set has priority over err_clr in the same cycle.
- FWFT=0: on ra, dout ← mem[rd_ptr] at that edge. Otherwise dout holds its previous value.
- FWFT=1: dout = mem[rd_ptr] combinationally. dout is don't-care while empty; the bench must not check it then. ra advances rd_ptr.
- Reset (any cycle, including mid-burst):
  - pointers = 0, count = 0, dout = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = 0, underflow = 0
  - memory contents are not cleared
- Rejected operations change neither the pointers nor the memory.

## Timing
- All status outputs decode combinationally from registered count. They change only after the clock edge on which wa/ra occur.
- Write-to-read latency:
  - FWFT=0: write at edge k → empty=0 after k → r_en at edge k+1 → data on dout after k+1.
  - FWFT=1: write at edge k → empty=0 and data on dout after k.
- Sustained throughput: one write and one read per cycle at any fill level, including full (pass-through) and count=1.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0 with no bubble.
- Flags update in the same cycle as the count transition that causes them:
  - almost_full on the edge count reaches AF_LEVEL
  - full on the edge count reaches DEPTH
- Error flags are visible the cycle after the offending request.

## Test plan
- Parameters for all scenarios: WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, FWFT=0 unless stated.
- Fill/drain: write 0x01..0x08 on consecutive cycles.
  - Expected after write 3: almost_empty=0. After write 6: almost_full=1. After write 8: full=1, count=8.
  - Then read 8 cycles → dout sequence 0x01..0x08, each one cycle after its r_en. Ends with empty=1, count=0.
- Overflow/underflow: with the FIFO full, write 0xAA → overflow=1, count stays 8, 0xAA is never read out.
  - Drain to empty, then assert r_en → underflow=1.
  - Pulse err_clr → both flags 0.
- Simultaneous read and write:
  - At full: write 0x55 with r_en → count stays 8, no overflow, 0x55 read eighth.
  - At empty: both asserted → underflow=1, count=1.
- Wrap-around: 20 writes interleaved with reads, keeping count between 3 and 5 → output order matches input order exactly, no flag glitches.
- Reset mid-operation: at count=5, assert reset for 1 cycle → count=0, empty=1, dout=0, flags cleared. Next write 0x3C is read back first.
- FWFT=1: write 0x77 at edge k → dout=0x77 and empty=0 immediately after k. r_en with count=1 → empty=1 after the following edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     r_en,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wa;
    logic             ra;

    always_comb begin
        full         = (count == (AW+1)'(DEPTH));
        empty        = (count == '0);
        almost_full  = (count >= (AW+1)'(AF_LEVEL));
        almost_empty = (count <= (AW+1)'(AE_LEVEL));
        ra           = r_en & ~empty;
        // a full FIFO still accepts a write when the same-cycle read frees a slot
        wa           = w_en & (~full | ra);
    end

    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ra) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wa && !ra) begin
                count <= count + (AW+1)'(1);
            end else if (ra && !wa) begin
                count <= count - (AW+1)'(1);
            end
            // setting wins over a same-cycle clear
            if (w_en && !wa) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign dout = mem[rd_ptr];
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q <= '0;
            end else if (ra) begin
                dout_q <= mem[rd_ptr];
            end
        end

        assign dout = dout_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a registered-read and an FWFT instance with identical stimulus and checks
// both against a queue-based FIFO model after every clock edge.
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic w_en = 1'b0;
    logic r_en = 1'b0;
    logic err_clr = 1'b0;
    logic [WIDTH-1:0] din = '0;

    logic [WIDTH-1:0] dout0, dout1;
    logic full0, empty0, af0, ae0, ovf0, udf0;
    logic full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] count0, count1;

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) dut_reg (
        .clk(clk), .reset(reset), .w_en(w_en), .din(din), .r_en(r_en), .err_clr(err_clr),
        .dout(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(udf0));

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .w_en(w_en), .din(din), .r_en(r_en), .err_clr(err_clr),
        .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(udf1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;
    logic [WIDTH-1:0] seen_out[$];
    logic [WIDTH-1:0] seen_in[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count_reg",  32'(count0), 32'(n));
        check("count_fwft", 32'(count1), 32'(n));
        check("empty",      32'(empty0), 32'(n == 0));
        check("full",       32'(full0),  32'(n == DEPTH));
        check("afull",      32'(af0),    32'(n >= AFL));
        check("aempty",     32'(ae0),    32'(n <= AEL));
        check("ovf",        32'(ovf0),   32'(m_ovf));
        check("udf",        32'(udf0),   32'(m_udf));
        check("fwft_flags", {26'd0, full1, empty1, af1, ae1, ovf1, udf1},
              {26'd0, n == DEPTH, n == 0, n >= AFL, n <= AEL, m_ovf, m_udf});
        check("dout_reg",   32'(dout0),  32'(m_dout));
        if (n != 0) check("dout_fwft", 32'(dout1), 32'(q[0]));
    endtask

    // One clock: apply inputs, advance the model with the pre-edge state, check outputs.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic c, input logic rs);
        logic ra, wa;
        w_en = w; din = d; r_en = r; err_clr = c; reset = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            ra = r && (q.size() != 0);
            wa = w && ((q.size() != DEPTH) || ra);
            if (w && !wa) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
            if (r && q.size() == 0) m_udf = 1'b1; else if (c) m_udf = 1'b0;
            if (ra) begin
                m_dout = q.pop_front();
                seen_out.push_back(m_dout);
            end
            if (wa) begin
                q.push_back(d);
                seen_in.push_back(d);
            end
        end
        #1;
        w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; reset = 1'b0;
        check_all();
    endtask

    initial begin
        // Reset state
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        check("reset_dout", 32'(dout0), 32'h0);

        // Fill 0x01..0x08, then rejected write at full
        for (int i = 1; i <= 8; i++) step(1, WIDTH'(i), 0, 0, 0);
        check("fill_full", 32'(full0), 32'h1);
        step(1, 8'hAA, 0, 0, 0);
        check("ovf_set", 32'(ovf0), 32'h1);

        // Drain: registered dout must walk 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(0, '0, 1, 0, 0);
            check("drain_seq", 32'(dout0), 32'(i));
        end
        step(0, '0, 1, 0, 0);
        check("udf_set", 32'(udf0), 32'h1);
        step(0, '0, 0, 1, 0);
        check("err_clr", {30'd0, ovf0, udf0}, 32'h0);

        // Pass-through write at full, then drain; 0x55 comes out eighth
        for (int i = 0; i < 8; i++) step(1, 8'h10 + WIDTH'(i), 0, 0, 0);
        step(1, 8'h55, 1, 0, 0);
        check("pass_ovf", 32'(ovf0), 32'h0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0);
        check("pass_eighth", 32'(dout0), 32'h55);

        // Read+write at empty: read rejected, write accepted
        step(1, 8'h66, 1, 0, 0);
        check("empty_rw_cnt", 32'(count0), 32'h1);
        step(0, '0, 1, 1, 0);

        // Wrap-around with occupancy held in 3..5
        for (int i = 0; i < 4; i++) step(1, WIDTH'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (q.size() <= 3)      step(1, WIDTH'($urandom), 0, 0, 0);
            else if (q.size() >= 5) step(0, '0, 1, 0, 0);
            else                    step(1, WIDTH'($urandom), $urandom_range(0, 1) == 1, 0, 0);
        end
        while (q.size() != 0) step(0, '0, 1, 0, 0);

        // Reset mid-operation at count 5
        for (int i = 0; i < 5; i++) step(1, WIDTH'(8'hC0 + i), 0, 0, 0);
        step(1, 8'h99, 1, 0, 1);
        check("midrst_dout", 32'(dout0), 32'h0);
        step(1, 8'h3C, 0, 0, 0);
        check("fwft_immediate", 32'(dout1), 32'h3C);
        step(0, '0, 1, 0, 0);
        check("after_rst_first", 32'(dout0), 32'h3C);
        check("fwft_drain_empty", 32'(empty1), 32'h1);

        // Random traffic, occasional clear and reset
        seen_in.delete(); seen_out.delete();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, WIDTH'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
        end
        step(0, '0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
